// File: rtl/sample_packetizer.sv
// Frames a continuous 64-bit sample stream into CHDR data packets (header + N payload words).
// Define SAMPLE_PACKETIZER_TIMESTAMP_EN to insert a 64-bit tick timestamp word after each header.
module sample_packetizer #(
  parameter logic [7:0] SR_PKT_WORDS = 8'd0,
  parameter logic [7:0] SR_SID       = 8'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        set_stb_i,
  input  logic [7:0]  set_addr_i,
  input  logic [31:0] set_data_i,
  input  logic [63:0] i_tdata,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  localparam logic [15:0] MAX_WORDS = 16'd8189;
`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
  localparam logic HAS_TIME = 1'b1;
`else
  localparam logic HAS_TIME = 1'b0;
`endif

`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
  typedef enum logic [1:0] {S_HDR = 2'd0, S_TIME = 2'd1, S_PAYLOAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_HDR = 2'd0, S_PAYLOAD = 2'd2} state_t;
`endif

  function automatic logic [15:0] clamp_words(input logic [15:0] v);
    if (v == 16'd0) begin
      clamp_words = 16'd1;
    end else if (v > MAX_WORDS) begin
      clamp_words = MAX_WORDS;
    end else begin
      clamp_words = v;
    end
  endfunction

  // Length counts header, optional timestamp and payload words, in bytes; clamp keeps it in 16 bits.
  function automatic logic [63:0] build_header(input logic [11:0] seq, input logic [15:0] words,
                                               input logic [31:0] sid);
    logic [15:0] total;
    total = words + 16'd1 + {15'd0, HAS_TIME};
    build_header = {2'b00, HAS_TIME, 1'b0, seq, total[12:0], 3'b000, sid};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [11:0] seq_r;
  logic [15:0] cnt_r;
  logic [15:0] pkt_words_r;
  logic [15:0] act_words_r;
  logic [31:0] sid_r;
  logic [63:0] data_s;
  logic        valid_s, last_s, ready_s;
  logic        hdr_fire_s, pay_fire_s, is_last_s;

  assign is_last_s = (cnt_r == (act_words_r - 16'd1));

  // Settings bus registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_words_r <= 16'd1;
      sid_r       <= 32'd0;
    end else if (set_stb_i) begin
      if (set_addr_i == SR_PKT_WORDS) begin
        pkt_words_r <= clamp_words(set_data_i[15:0]);
      end
      if (set_addr_i == SR_SID) begin
        sid_r <= set_data_i;
      end
    end
  end

`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
  logic [63:0] tick_r;
  logic [63:0] time_r;

  // Free-running tick counter and its snapshot taken on the header handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_r <= 64'd0;
      time_r <= 64'd0;
    end else begin
      tick_r <= tick_r + 64'd1;
      if (hdr_fire_s) begin
        time_r <= tick_r;
      end
    end
  end
`endif

  // Framing state, active packet length, word counter and sequence number
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= S_HDR;
      seq_r       <= 12'd0;
      cnt_r       <= 16'd0;
      act_words_r <= 16'd1;
    end else begin
      state_r <= state_nxt_s;
      if (hdr_fire_s) begin
        act_words_r <= pkt_words_r;
        cnt_r       <= 16'd0;
      end else if (pay_fire_s) begin
        cnt_r <= cnt_r + 16'd1;
        if (is_last_s) begin
          seq_r <= seq_r + 12'd1;
        end
      end
    end
  end

  // Next-state and output decode; payload is a zero-latency pass-through
  always_comb begin
    state_nxt_s = state_r;
    data_s      = 64'd0;
    valid_s     = 1'b0;
    last_s      = 1'b0;
    ready_s     = 1'b0;
    hdr_fire_s  = 1'b0;
    pay_fire_s  = 1'b0;
    case (state_r)
      S_HDR: begin
        data_s  = build_header(seq_r, pkt_words_r, sid_r);
        valid_s = i_tvalid;
        if (i_tvalid && o_tready) begin
          hdr_fire_s = 1'b1;
`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
          state_nxt_s = S_TIME;
`else
          state_nxt_s = S_PAYLOAD;
`endif
        end else begin
          state_nxt_s = S_HDR;
        end
      end
`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
      S_TIME: begin
        data_s  = time_r;
        valid_s = 1'b1;
        if (o_tready) begin
          state_nxt_s = S_PAYLOAD;
        end else begin
          state_nxt_s = S_TIME;
        end
      end
`endif
      S_PAYLOAD: begin
        data_s  = i_tdata;
        valid_s = i_tvalid;
        ready_s = o_tready;
        last_s  = is_last_s;
        if (i_tvalid && o_tready) begin
          pay_fire_s  = 1'b1;
          state_nxt_s = is_last_s ? S_HDR : S_PAYLOAD;
        end else begin
          state_nxt_s = S_PAYLOAD;
        end
      end
      default: begin
        state_nxt_s = S_HDR;
      end
    endcase
  end

  // Outputs are held at their idle values for as long as reset is asserted
  assign o_tdata  = rst_ni ? data_s  : 64'd0;
  assign o_tvalid = rst_ni ? valid_s : 1'b0;
  assign o_tlast  = rst_ni ? last_s  : 1'b0;
  assign i_tready = rst_ni ? ready_s : 1'b0;

endmodule

// File: tb/tb_sample_packetizer.sv
// Scoreboard bench for sample_packetizer: packet-level reference model feeds an expected-word queue,
// a negedge monitor pops and compares every output handshake and checks stability under stall.
module tb_sample_packetizer;

`ifdef SAMPLE_PACKETIZER_TIMESTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        set_stb_i;
  logic [7:0]  set_addr_i;
  logic [31:0] set_data_i;
  logic [63:0] i_tdata;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  always #5 clk = ~clk;

  sample_packetizer #(.SR_PKT_WORDS(8'd0), .SR_SID(8'd1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .set_stb_i(set_stb_i), .set_addr_i(set_addr_i),
    .set_data_i(set_data_i), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    bit          is_hdr;
    bit          is_time;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          popped = 0;
  int          sink_mode = 0;
  bit          rand_in = 1'b0;
  int          m_words = 1;
  logic [31:0] m_sid = 32'd0;
  int          m_seq = 0;
  logic [63:0] tb_tick;
  logic [63:0] hdr_tick = 64'd0;

  // Reference tick: clock edges since reset release
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) tb_tick <= 64'd0;
    else         tb_tick <= tb_tick + 64'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: one packet = header, optional timestamp, m_words payload words
  task automatic send_pkt(input logic [63:0] base, input bit use_base);
    exp_t e;
    logic [63:0] d;
    int len;
    len = 8 * (m_words + 1 + TS);
    e.data = {2'b00, TS[0], 1'b0, 12'(m_seq), 16'(len), m_sid};
    e.last = 1'b0; e.is_hdr = 1'b1; e.is_time = 1'b0;
    exp_q.push_back(e);
    if (TS != 0) begin
      e.data = 64'd0; e.is_hdr = 1'b0; e.is_time = 1'b1;
      exp_q.push_back(e);
    end
    for (int w = 0; w < m_words; w++) begin
      d = use_base ? base + 64'(w) : {$urandom, $urandom};
      src_q.push_back(d);
      e.data = d; e.last = (w == m_words - 1); e.is_hdr = 1'b0; e.is_time = 1'b0;
      exp_q.push_back(e);
    end
    m_seq = (m_seq + 1) % 4096;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_stb_i = 1'b1; set_addr_i = a; set_data_i = d;
    @(posedge clk); #1;
    set_stb_i = 1'b0;
  endtask

  task automatic set_words(input logic [31:0] d);
    int v;
    wr(8'd0, d);
    v = int'(d[15:0]);
    m_words = (v == 0) ? 1 : ((v > 8189) ? 8189 : v);
  endtask

  task automatic set_sid(input logic [31:0] d);
    wr(8'd1, d);
    m_sid = d;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && c < budget) begin
      @(posedge clk); c++;
    end
    n_checks++;
    if (exp_q.size() == 0 && src_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_timeout: got %0d words outstanding expected 0", nm, exp_q.size());
      exp_q.delete(); src_q.delete();
    end
  endtask

  task automatic wait_popped(input int target, input int budget);
    int c = 0;
    while (popped < target && c < budget) begin
      @(negedge clk); c++;
    end
    n_checks++;
    if (popped >= target) n_pass++;
    else $display("FAIL progress_timeout: got %0d words expected %0d", popped, target);
  endtask

  // Input driver: holds a word until accepted, optional random valid gaps between words
  initial begin
    bit fire;
    forever begin
      @(negedge clk);
      fire = i_tvalid && i_tready;
      @(posedge clk); #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() == 0) i_tvalid = 1'b0;
      else if (i_tvalid && !fire) i_tdata = src_q[0];
      else if (!rand_in || $urandom_range(0, 3) != 0) begin
        i_tvalid = 1'b1; i_tdata = src_q[0];
      end else i_tvalid = 1'b0;
    end
  end

  // Output sink: always ready, random, or toggling
  initial begin
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0: o_tready = 1'b1;
        1: o_tready = ($urandom_range(0, 9) < 7);
        default: o_tready = !o_tready;
      endcase
    end
  end

  // Monitor: scoreboard pop on every output handshake, stability check on every stall
  initial begin
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0; prev_data = 64'd0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(o_tvalid), 64'd1);
          chk("stall_data", o_tdata, prev_data);
          chk("stall_last", 64'(o_tlast), 64'(prev_last));
        end
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %h expected nothing", o_tdata);
          end else begin
            e = exp_q.pop_front();
            popped++;
            if (e.is_hdr) hdr_tick = tb_tick;
            chk(e.is_hdr ? "header" : (e.is_time ? "timestamp" : "payload"), o_tdata,
                e.is_time ? hdr_tick : e.data);
            chk("tlast", 64'(o_tlast), 64'(e.last));
          end
        end
        prev_stall = o_tvalid && !o_tready;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
      end
    end
  end

  initial begin
    int start;
    rst_ni = 1'b0; set_stb_i = 1'b0; set_addr_i = 8'd0; set_data_i = 32'd0;
    i_tvalid = 1'b1; i_tdata = 64'h1234; o_tready = 1'b1;
    #3;
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    chk("rst_o_tdata", o_tdata, 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    #20 rst_ni = 1'b1;

    // Directed: 4-word packets with counting data
    set_words(32'd4);
    set_sid(32'h0010_0020);
    send_pkt(64'd0, 1'b1);
    send_pkt(64'd4, 1'b1);
    wait_drain("basic", 200);

    // Zero length stored as one word
    set_words(32'd0);
    send_pkt(64'hA5A5, 1'b1);
    send_pkt(64'd0, 1'b0);
    wait_drain("single", 200);

    // Toggling backpressure
    set_words(32'd2);
    sink_mode = 2;
    send_pkt(64'd0, 1'b1);
    send_pkt(64'd2, 1'b1);
    wait_drain("toggle", 200);

    // Random traffic with random lengths and SIDs
    rand_in = 1'b1; sink_mode = 1;
    for (int b = 0; b < 6; b++) begin
      set_words(32'($urandom_range(1, 6)));
      set_sid($urandom);
      for (int p = 0; p < 3; p++) send_pkt(64'd0, 1'b0);
      wait_drain("random", 2000);
    end

    // SID write while a payload is in flight only affects the next packet
    rand_in = 1'b0; sink_mode = 0;
    set_words(32'd4);
    start = popped;
    send_pkt(64'd0, 1'b0);
    m_sid = 32'h0000_BEEF;
    send_pkt(64'd0, 1'b0);
    wait_popped(start + 2, 200);
    wr(8'd1, 32'h0000_BEEF);
    wait_drain("sid_change", 200);

    // Length above the limit clamps to 8189; upper data bits ignored
    set_words(32'h0001_2000);
    send_pkt(64'd0, 1'b0);
    wait_drain("clamp", 20000);

    // Reset mid-payload
    set_words(32'd4);
    start = popped;
    send_pkt(64'd0, 1'b0);
    wait_popped(start + 2, 200);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("midrst_i_tready", 64'(i_tready), 64'd0);
    chk("midrst_o_tdata", o_tdata, 64'd0);
    exp_q.delete(); src_q.delete();
    m_seq = 0; m_words = 1; m_sid = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;

    // Register defaults after reset, then seqnum wrap across 4097 packets
    for (int p = 0; p < 4097; p++) send_pkt(64'd0, 1'b0);
    wait_drain("wrap", 20000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
